seq_mult4: RTL and testbench

SEQ_MULT4 -- requirements
Module: seq_mult4

---
 rtl/seq_mult4.sv | 78 +++++++
 tb/tb_seq_mult4.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult4.sv
// seq_mult4: 4x4 unsigned shift-add multiplier; define SEQ_MULT4_EARLY_EXIT_EN to end CALC once the multiplier is exhausted
module seq_mult4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [3:0]  mplier_q, mplier_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  p_q, p_d;
  logic        last;
  // next state: one shift-add step per CALC cycle; IDLE and DONE both accept a new start
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    last     = 1'b0;
    case (state_q)
      CALC: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : 8'h00);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 2'd1;
`ifdef SEQ_MULT4_EARLY_EXIT_EN
        last     = (mplier_d == 4'h0);
`else
        last     = (cnt_q == 2'd3);
`endif
        if (last) begin
          state_d = DONE;
          p_d     = acc_d;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d  = CALC;
          mcand_d  = {4'h0, A};
          mplier_d = B;
          acc_d    = 8'h00;
          cnt_d    = 2'd0;
        end
      end
    endcase
  end
  // state registers with synchronous reset that aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= 8'h00;
      mplier_q <= 4'h0;
      acc_q    <= 8'h00;
      cnt_q    <= 2'd0;
      p_q      <= 8'h00;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end
  assign P    = p_q;
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_mult4.sv
// tb_seq_mult4: directed table plus corner sequences and full sweep for seq_mult4
module tb_seq_mult4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic [7:0] P;
  logic       busy;
  logic       done;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int         lat_full;
    int         lat_early;
  } vec_t;
  vec_t vt[10];

  seq_mult4 dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .P(P), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] b);
`ifdef SEQ_MULT4_EARLY_EXIT_EN
    return b[3] ? 4 : b[2] ? 3 : b[1] ? 2 : 1;
`else
    return 4;
`endif
  endfunction

  // counts busy cycles (bounded) after start was sampled; returns with DUT in the expected DONE cycle
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 10) begin
      n++;
      tick();
    end
  endtask

  task automatic run_mult(input string nm, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input int lat);
    int n;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    chk({nm, " latency"}, n, lat);
    chk({nm, " done"}, done, 1);
    chk({nm, " P"}, P, exp_p);
    tick();
    chk({nm, " done width"}, done, 0);
    chk({nm, " P hold"}, P, exp_p);
  endtask

  initial begin
    int n;
    int gap;
    vt[0] = '{4'd15, 4'd15, 8'hE1, 4, 4};
    vt[1] = '{4'd7,  4'd3,  8'h15, 4, 2};
    vt[2] = '{4'd3,  4'd5,  8'h0F, 4, 3};
    vt[3] = '{4'd9,  4'd2,  8'h12, 4, 2};
    vt[4] = '{4'd0,  4'd0,  8'h00, 4, 1};
    vt[5] = '{4'd1,  4'd1,  8'h01, 4, 1};
    vt[6] = '{4'd8,  4'd8,  8'h40, 4, 4};
    vt[7] = '{4'd5,  4'd12, 8'h3C, 4, 4};
    vt[8] = '{4'd6,  4'd2,  8'h0C, 4, 2};
    vt[9] = '{4'd13, 4'd7,  8'h5B, 4, 3};

    // reset for 2 cycles with start asserted alongside, then 10 idle cycles
    reset = 1'b1;
    start = 1'b1;
    A = 4'd5;
    B = 4'd5;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle P", P, 0);
      chk("idle busy", busy, 0);
      chk("idle done", done, 0);
      tick();
    end

    // directed table
    for (int i = 0; i < 10; i++) begin
`ifdef SEQ_MULT4_EARLY_EXIT_EN
      run_mult($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p, vt[i].lat_early);
`else
      run_mult($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p, vt[i].lat_full);
`endif
      tick();
    end

    // operands change and start stays high during CALC
    A = 4'd7;
    B = 4'd3;
    start = 1'b1;
    tick();
    A = 4'd0;
    B = 4'd0;
    wait_busy(n);
    start = 1'b0;
    chk("hold latency", n, exp_lat(4'd3));
    chk("hold done", done, 1);
    chk("hold P", P, 8'h15);
    tick();
    chk("hold single done", done, 0);
    chk("hold no restart", busy, 0);
    tick();
    chk("hold idle", busy | done, 0);

    // back-to-back start in the DONE cycle
    A = 4'd3;
    B = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    chk("b2b first done", done, 1);
    chk("b2b first P", P, 8'h0F);
    A = 4'd9;
    B = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b restart busy", busy, 1);
    chk("b2b P held in CALC", P, 8'h0F);
    gap = 1;
    while (!done && gap < 12) begin
      gap++;
      tick();
    end
    chk("b2b done spacing", gap, exp_lat(4'd2) + 1);
    chk("b2b second P", P, 8'h12);
    tick();
    chk("b2b second done width", done, 0);

    // reset during the 3rd CALC cycle aborts without a done pulse
    A = 4'd12;
    B = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort busy", busy, 1);
    chk("abort P held", P, 8'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort P", P, 0);
    chk("abort busy cleared", busy, 0);
    chk("abort done", done, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += int'(done) + int'(busy);
      tick();
    end
    chk("abort stays idle", n, 0);

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_mult($sformatf("sweep %0dx%0d", a, b), 4'(a), 4'(b), 8'(a * b), exp_lat(4'(b)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
